// File: rtl/buf_pingpong_ctrl_pkg.sv
// buf_pingpong_ctrl_pkg: bank state encodings and geometry of the 208-word pixel buffer.
package buf_pingpong_ctrl_pkg;
   typedef enum logic [1:0] {EMPTY = 2'd0, FILLING = 2'd1, FULL = 2'd2, DRAINING = 2'd3} bank_st_t;
   localparam int BUF_ADDR_W     = 8;
   localparam int BUF_OFS_W      = 7;
   localparam int BUF_BANK_DEPTH = 104;
   localparam int BUF_BANK_BASE0 = 0;
   localparam int BUF_BANK_BASE1 = 104;
endpackage

// File: rtl/buf_bank_fsm.sv
// buf_bank_fsm: ownership state of one buffer bank, EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
module buf_bank_fsm
   import buf_pingpong_ctrl_pkg::*;
#(
   parameter logic RST_FILL = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       grant_wr,
   input  logic       done_wr,
   input  logic       start_rd,
   input  logic       done_rd,
   output logic [1:0] st
);
   bank_st_t cur, nxt;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cur <= RST_FILL ? FILLING : EMPTY;
      else cur <= nxt;

   always_comb begin
      nxt = cur;
      case (cur)
         EMPTY:    nxt = grant_wr ? FILLING : EMPTY;
         FILLING:  nxt = done_wr ? FULL : FILLING;
         FULL:     nxt = done_rd ? EMPTY : start_rd ? DRAINING : FULL;
         DRAINING: nxt = done_rd ? EMPTY : DRAINING;
         default:  nxt = EMPTY;
      endcase
   end

   assign st = cur;
endmodule

// File: rtl/buf_pingpong_ctrl.sv
// buf_pingpong_ctrl: ping-pong bank ownership and RAM port control for the 64x208 pixel buffer.
// Define BUF_PINGPONG_ERR_EN to build the sticky protocol-error flag; otherwise err is tied low.
module buf_pingpong_ctrl
   import buf_pingpong_ctrl_pkg::*;
#(
   parameter int ADDR_W     = BUF_ADDR_W,
   parameter int BANK_DEPTH = BUF_BANK_DEPTH,
   parameter int OFS_W      = BUF_OFS_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_valid,
   input  logic [1:0]        wr_we,
   input  logic [OFS_W-1:0]  wr_ofs,
   input  logic              wr_done,
   output logic              wr_ready,
   input  logic              rd_en,
   input  logic              rd_done,
   output logic              rd_avail,
   output logic              rd_vld,
   output logic [OFS_W-1:0]  rd_ofs,
   output logic [1:0]        ram_a_we,
   output logic [ADDR_W-1:0] ram_a_addr,
   output logic              ram_b_re,
   output logic [ADDR_W-1:0] ram_b_addr,
   output logic              err
);
   localparam logic [OFS_W-1:0]  LAST = OFS_W'(BANK_DEPTH);
   localparam logic [ADDR_W-1:0] B0   = ADDR_W'(BUF_BANK_BASE0);
   localparam logic [ADDR_W-1:0] B1   = ADDR_W'(BUF_BANK_BASE1);

   logic [1:0]       st [2];
   logic             wr_bank, rd_bank, ofs_ok, wr_fire, rd_fire, rd_go;
   logic [OFS_W-1:0] rd_cnt;

   assign wr_ready   = st[wr_bank] == FILLING;
   assign rd_avail   = st[rd_bank] == FULL || st[rd_bank] == DRAINING;
   assign ofs_ok     = wr_ofs < LAST;
   assign ram_a_we   = wr_valid && wr_ready && ofs_ok ? wr_we : 2'b00;
   assign ram_a_addr = ADDR_W'(wr_ofs) + (wr_bank ? B1 : B0);
   assign wr_fire    = wr_done && wr_ready;
   assign rd_fire    = rd_done && rd_avail;
   assign rd_go      = rd_en && rd_avail && rd_cnt < LAST;
   assign ram_b_re   = rd_go;
   assign ram_b_addr = ADDR_W'(rd_cnt) + (rd_bank ? B1 : B0);

   // An empty bank is handed to the writer when it is the writer's next bank or the writer just finished.
   for (genvar i = 0; i < 2; i++) begin : g_bank
      buf_bank_fsm #(.RST_FILL(i == 0)) u_fsm (
         .clk      (clk),
         .rst_n    (rst_n),
         .grant_wr (st[i] == EMPTY && (wr_bank == 1'(i) || wr_fire)),
         .done_wr  (wr_fire && wr_bank == 1'(i)),
         .start_rd (rd_en && rd_bank == 1'(i)),
         .done_rd  (rd_fire && rd_bank == 1'(i)),
         .st       (st[i])
      );
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_bank <= 1'b0;
         rd_bank <= 1'b0;
         rd_cnt  <= '0;
         rd_vld  <= 1'b0;
         rd_ofs  <= '0;
      end else begin
         wr_bank <= wr_bank ^ wr_fire;
         rd_bank <= rd_bank ^ rd_fire;
         rd_cnt  <= rd_fire ? '0 : rd_cnt + OFS_W'(rd_go);
         rd_vld  <= rd_go;
         if (rd_go) rd_ofs <= rd_cnt;
      end

`ifdef BUF_PINGPONG_ERR_EN
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) err <= 1'b0;
      else if ((wr_valid && !ofs_ok) || (wr_done && !wr_ready) || ((rd_done || rd_en) && !rd_avail)) err <= 1'b1;
`else
   assign err = 1'b0;
`endif
endmodule

// File: tb/tb_buf_pingpong_ctrl.sv
// tb_buf_pingpong_ctrl: randomized scenario bench for buf_pingpong_ctrl with an address/ownership reference model.
module tb_buf_pingpong_ctrl;
`ifdef BUF_PINGPONG_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif
   localparam int DEPTH = 104;

   logic       clk = 1'b0, rst_n = 1'b0;
   logic       wr_valid = 0, wr_done = 0, rd_en = 0, rd_done = 0;
   logic [1:0] wr_we = 0;
   logic [6:0] wr_ofs = 0;
   logic       wr_ready, rd_avail, rd_vld, ram_b_re, err;
   logic [6:0] rd_ofs;
   logic [1:0] ram_a_we;
   logic [7:0] ram_a_addr, ram_b_addr;
   int         total = 0, bad = 0;

   buf_pingpong_ctrl dut (
      .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_we(wr_we), .wr_ofs(wr_ofs),
      .wr_done(wr_done), .wr_ready(wr_ready), .rd_en(rd_en), .rd_done(rd_done),
      .rd_avail(rd_avail), .rd_vld(rd_vld), .rd_ofs(rd_ofs), .ram_a_we(ram_a_we),
      .ram_a_addr(ram_a_addr), .ram_b_re(ram_b_re), .ram_b_addr(ram_b_addr), .err(err)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_valid = 0; wr_done = 0; rd_en = 0; rd_done = 0; wr_we = 0;
   endtask

   task automatic test_reset();
      idle();
      rst_n = 0;
      repeat (3) step();
      rst_n = 1;
      step();
      total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL reset_wr_ready got=%b exp=1", wr_ready); end
      total++; if (rd_avail !== 1'b0) begin bad++; $display("FAIL reset_rd_avail got=%b exp=0", rd_avail); end
      total++; if (ram_a_we !== 2'b00) begin bad++; $display("FAIL reset_ram_a_we got=%b exp=00", ram_a_we); end
      total++; if (ram_b_re !== 1'b0) begin bad++; $display("FAIL reset_ram_b_re got=%b exp=0", ram_b_re); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
      total++; if (rd_vld !== 1'b0 || rd_ofs !== 7'd0) begin bad++; $display("FAIL reset_rd_vld got=%b/%0d exp=0/0", rd_vld, rd_ofs); end
   endtask

   task automatic test_fill_bank0();
      int ofs = 0, n = 0;
      bit wv;
      while (ofs < DEPTH) begin
         if (n++ > 1000) begin total++; bad++; $display("FAIL fill0_timeout ofs=%0d", ofs); break; end
         wv = $urandom_range(0, 3) != 0;
         wr_valid = wv; wr_we = 2'b11; wr_ofs = 7'(ofs);
         #1;
         total++; if (ram_a_we !== (wv ? 2'b11 : 2'b00)) begin bad++; $display("FAIL fill0_we ofs=%0d got=%b exp=%b", ofs, ram_a_we, wv ? 2'b11 : 2'b00); end
         total++; if (ram_a_addr !== 8'(ofs)) begin bad++; $display("FAIL fill0_addr got=%0d exp=%0d", ram_a_addr, ofs); end
         total++; if (rd_avail !== 1'b0) begin bad++; $display("FAIL fill0_rd_avail got=%b exp=0", rd_avail); end
         if (wv) ofs++;
         step();
      end
      idle();
      wr_done = 1;
      step();
      wr_done = 0;
      #1;
      total++; if (rd_avail !== 1'b1) begin bad++; $display("FAIL fill0_done_rd_avail got=%b exp=1", rd_avail); end
      total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL fill0_done_wr_ready got=%b exp=1", wr_ready); end
   endtask

   task automatic test_halfword();
      wr_valid = 1; wr_ofs = 7'd5; wr_we = 2'b01;
      #1;
      total++; if (ram_a_we !== 2'b01 || ram_a_addr !== 8'd109) begin bad++; $display("FAIL half_lo got=%b@%0d exp=01@109", ram_a_we, ram_a_addr); end
      step();
      wr_we = 2'b10;
      #1;
      total++; if (ram_a_we !== 2'b10 || ram_a_addr !== 8'd109) begin bad++; $display("FAIL half_hi got=%b@%0d exp=10@109", ram_a_we, ram_a_addr); end
      step();
      idle();
   endtask

   task automatic test_overlap();
      int rcnt = 0, wofs = 0, extra = 0, n = 0, pofs = 0;
      bit pre = 0, en, wv, exp_re;
      while (!(rcnt == DEPTH && extra >= 3 && wofs == DEPTH)) begin
         if (n++ > 3000) begin total++; bad++; $display("FAIL overlap_timeout rcnt=%0d wofs=%0d", rcnt, wofs); break; end
         en = $urandom_range(0, 1) == 1;
         wv = wofs < DEPTH && $urandom_range(0, 1) == 1;
         rd_en = en; wr_valid = wv; wr_we = 2'b11; wr_ofs = 7'(wofs);
         exp_re = en && rcnt < DEPTH;
         #1;
         total++; if (ram_b_re !== exp_re) begin bad++; $display("FAIL ovl_b_re rcnt=%0d got=%b exp=%b", rcnt, ram_b_re, exp_re); end
         if (exp_re) begin total++; if (ram_b_addr !== 8'(rcnt)) begin bad++; $display("FAIL ovl_b_addr got=%0d exp=%0d", ram_b_addr, rcnt); end end
         total++; if (rd_vld !== pre) begin bad++; $display("FAIL ovl_rd_vld got=%b exp=%b", rd_vld, pre); end
         if (pre) begin total++; if (rd_ofs !== 7'(pofs)) begin bad++; $display("FAIL ovl_rd_ofs got=%0d exp=%0d", rd_ofs, pofs); end end
         total++; if (ram_a_we !== (wv ? 2'b11 : 2'b00)) begin bad++; $display("FAIL ovl_a_we got=%b exp=%b", ram_a_we, wv ? 2'b11 : 2'b00); end
         if (wv) begin total++; if (ram_a_addr !== 8'(DEPTH + wofs)) begin bad++; $display("FAIL ovl_a_addr got=%0d exp=%0d", ram_a_addr, DEPTH + wofs); end end
         if (en && rcnt == DEPTH) extra++;
         pre = exp_re; pofs = rcnt;
         if (exp_re) rcnt++;
         if (wv) wofs++;
         step();
      end
      idle();
      wr_done = 1; rd_done = 1;
      #1;
      total++; if (rd_vld !== pre) begin bad++; $display("FAIL ovl_last_vld got=%b exp=%b", rd_vld, pre); end
      step();
      idle();
      #1;
      total++; if (rd_avail !== 1'b1) begin bad++; $display("FAIL ovl_swap_rd_avail got=%b exp=1", rd_avail); end
      total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL ovl_swap_wr_ready got=%b exp=0", wr_ready); end
      step();
      total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL ovl_refill_wr_ready got=%b exp=1", wr_ready); end
   endtask

   task automatic test_stall();
      int k, o;
      repeat ($urandom_range(2, 6)) begin
         o = $urandom_range(0, DEPTH - 1);
         wr_valid = 1; wr_we = 2'($urandom_range(1, 3)); wr_ofs = 7'(o);
         #1;
         total++; if (ram_a_we !== wr_we || ram_a_addr !== 8'(o)) begin bad++; $display("FAIL stall_pre_write got=%b@%0d exp=%b@%0d", ram_a_we, ram_a_addr, wr_we, o); end
         step();
      end
      idle();
      wr_done = 1;
      step();
      idle();
      repeat ($urandom_range(2, 5)) begin
         wr_valid = 1; wr_we = 2'b11; wr_ofs = 7'($urandom_range(0, DEPTH - 1));
         #1;
         total++; if (wr_ready !== 1'b0 || ram_a_we !== 2'b00) begin bad++; $display("FAIL stall_blocked got=%b/%b exp=0/00", wr_ready, ram_a_we); end
         step();
      end
      idle();
      k = $urandom_range(1, 20);
      rd_en = 1;
      for (int i = 0; i < k; i++) begin
         #1;
         total++; if (ram_b_re !== 1'b1 || ram_b_addr !== 8'(DEPTH + i)) begin bad++; $display("FAIL stall_read got=%b@%0d exp=1@%0d", ram_b_re, ram_b_addr, DEPTH + i); end
         step();
         total++; if (rd_vld !== 1'b1 || rd_ofs !== 7'(i)) begin bad++; $display("FAIL stall_rd_vld got=%b/%0d exp=1/%0d", rd_vld, rd_ofs, i); end
      end
      rd_en = 0; rd_done = 1;
      step();
      rd_done = 0;
      #1;
      total++; if (wr_ready !== 1'b0 || rd_avail !== 1'b1) begin bad++; $display("FAIL stall_release got=%b/%b exp=0/1", wr_ready, rd_avail); end
      step();
      total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL stall_resume_wr_ready got=%b exp=1", wr_ready); end
      rd_en = 1;
      #1;
      total++; if (ram_b_re !== 1'b1 || ram_b_addr !== 8'd0) begin bad++; $display("FAIL stall_next_bank got=%b@%0d exp=1@0", ram_b_re, ram_b_addr); end
      step();
      rd_en = 0;
      total++; if (rd_vld !== 1'b1 || rd_ofs !== 7'd0) begin bad++; $display("FAIL stall_next_vld got=%b/%0d exp=1/0", rd_vld, rd_ofs); end
   endtask

   task automatic test_errors();
      #1;
      total++; if (err !== 1'b0) begin bad++; $display("FAIL err_clean got=%b exp=0", err); end
      wr_valid = 1; wr_we = 2'b11; wr_ofs = 7'($urandom_range(DEPTH, 127));
      #1;
      total++; if (wr_ready !== 1'b1 || ram_a_we !== 2'b00) begin bad++; $display("FAIL err_bad_ofs_write got=%b/%b exp=1/00", wr_ready, ram_a_we); end
      step();
      idle();
      repeat ($urandom_range(2, 6)) begin
         total++; if (err !== ERR_EN) begin bad++; $display("FAIL err_bad_ofs_sticky got=%b exp=%b", err, ERR_EN); end
         step();
      end
      rst_n = 0;
      #1;
      total++; if (err !== 1'b0 || wr_ready !== 1'b1 || rd_avail !== 1'b0) begin bad++; $display("FAIL err_midreset got=%b/%b/%b exp=0/1/0", err, wr_ready, rd_avail); end
      total++; if (rd_vld !== 1'b0 || ram_b_re !== 1'b0 || ram_a_we !== 2'b00) begin bad++; $display("FAIL err_midreset_ram got=%b/%b/%b exp=0/0/00", rd_vld, ram_b_re, ram_a_we); end
      step();
      rst_n = 1;
      step();
      rd_en = 1;
      #1;
      total++; if (ram_b_re !== 1'b0) begin bad++; $display("FAIL err_rd_empty_re got=%b exp=0", ram_b_re); end
      step();
      rd_en = 0;
      total++; if (err !== ERR_EN || rd_vld !== 1'b0) begin bad++; $display("FAIL err_rd_empty got=%b/%b exp=%b/0", err, rd_vld, ERR_EN); end
      rst_n = 0;
      step();
      rst_n = 1;
      step();
      rd_done = 1;
      step();
      rd_done = 0;
      total++; if (err !== ERR_EN || rd_avail !== 1'b0 || wr_ready !== 1'b1) begin bad++; $display("FAIL err_rd_done_empty got=%b/%b/%b exp=%b/0/1", err, rd_avail, wr_ready, ERR_EN); end
   endtask

   initial begin
      test_reset();
      test_fill_bank0();
      test_halfword();
      test_overlap();
      test_stall();
      test_errors();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/buf_pingpong_ctrl.md
Name: buf_pingpong_ctrl

Overview:
- Ping-pong controller for the 2-port 64x208 pixel buffer (8 pixels/word, 208 words, half-word write enables).
- Splits the RAM into two 104-word banks. A producer (deblocking/reconstruction write-back) fills one bank while a consumer (coefficient/output fetch) drains the other.
- Tracks bank ownership, generates the RAM port A and port B controls, and flags read data valid one cycle after each read.

Parameters:
- ADDR_W, 8, RAM address width.
- BANK_DEPTH, 104, words per bank; bank 0 = 0..103, bank 1 = 104..207.
- OFS_W, 7, width of in-bank offset.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- wr_valid  in  1  producer write beat
- wr_we  in  2  half-word enables; [0] = pixels 0-3, [1] = pixels 4-7
- wr_ofs  in  OFS_W  word offset within the current write bank
- wr_done  in  1  pulse: current write bank complete
- wr_ready  out  1  a bank is owned by the writer
- rd_en  in  1  consumer requests the next word
- rd_done  in  1  pulse: consumer releases the current read bank
- rd_avail  out  1  a full bank is owned by the reader
- rd_vld  out  1  b_data_o valid this cycle (RAM data passes directly to the consumer)
- rd_ofs  out  OFS_W  offset of the word currently valid
- ram_a_we  out  2  to RAM a_we
- ram_a_addr  out  ADDR_W  to RAM a_addr
- ram_b_re  out  1  to RAM b_re
- ram_b_addr  out  ADDR_W  to RAM b_addr
- err  out  1  sticky protocol error (optional, see below)

Behaviour:
- Bank state: per bank, 2-bit state EMPTY(0) -> FILLING(1) -> FULL(2) -> DRAINING(3) -> EMPTY.
- Pointers: wr_bank and rd_bank are 1-bit registers.
- Reset (async, rst_n=0):
  - both banks EMPTY, then bank 0 immediately FILLING; wr_bank=0, rd_bank=0.
  - rd_vld=0, rd_ofs=0, err=0; all RAM controls 0.
- wr_ready = (state[wr_bank]==FILLING).
- Port A is combinational:
  - ram_a_we = wr_valid & wr_ready ? wr_we : 0.
  - ram_a_addr = wr_bank ? wr_ofs+104 : wr_ofs, computed at ADDR_W width.
  - wr_ofs>=BANK_DEPTH: write suppressed (ram_a_we=0); err set.
- wr_done while FILLING:
  - state[wr_bank] <= FULL; wr_bank toggles.
  - If the other bank is EMPTY it becomes FILLING in the same cycle; otherwise wr_ready stays 0 until it empties.
- rd_avail = state[rd_bank]==FULL or DRAINING.
  - First rd_en on a FULL bank moves it to DRAINING.
- Read sequencing:
  - rd_cnt is an internal OFS_W counter, reset to 0 on each bank handover.
  - rd_en & rd_avail & rd_cnt<BANK_DEPTH: ram_b_re=1, ram_b_addr = bank base + rd_cnt, rd_cnt increments.
  - Read latency is 1 cycle: rd_vld and rd_ofs are registered copies of ram_b_re and rd_cnt.
  - rd_en with rd_cnt==BANK_DEPTH: ignored, no wrap.
- rd_done while DRAINING/FULL:
  - state[rd_bank] <= EMPTY; rd_bank toggles; rd_cnt <= 0.
  - If wr_bank points at this bank and the writer is idle, the bank goes EMPTY->FILLING next cycle.
- Simultaneous events:
  - wr_done and rd_done on different banks in the same cycle: both take effect; the freed bank becomes FILLING one cycle later.
  - Writer and reader never own the same bank at once.
- Error cases (no state change, err set):
  - wr_done when not FILLING.
  - rd_done when not readable.
  - rd_en when !rd_avail.
- Reset mid-operation discards all bank contents logically; RAM contents are not cleared.

Optional Feature:
- BUF_PINGPONG_ERR_EN defined: err is a sticky register, cleared only by reset, set by any error case above.
- Undefined: err tied to 0 and error-detect logic removed. Suppression of illegal writes/reads remains in both builds.

Decomposition:
- Shared package/defines file (alongside enc_defines.v):
  - bank state encodings EMPTY/FILLING/FULL/DRAINING.
  - BANK_DEPTH=104 and bank base addresses 0/104.
- One natural sub-module, buf_bank_fsm: a per-bank 4-state FSM with inputs grant_wr, done_wr, start_rd, done_rd; instantiated twice.
- Address generation and the read counter stay in the top module.

Test Plan:
- Reset check: release rst_n -> wr_ready=1, rd_avail=0, ram_a_we=0, ram_b_re=0, err=0.
- Fill and drain bank 0:
  - stimulus: write ofs 0..103 with wr_we=2'b11, then wr_done; then 104 rd_en pulses.
  - required: ram_a_addr 0..103; rd_avail=1; ram_b_addr 0..103; rd_vld one cycle after each ram_b_re, with rd_ofs matching.
- Half-word writes to bank 1:
  - stimulus: after the first wr_done, wr_we=2'b01 then 2'b10 at ofs 5.
  - required: ram_a_addr=109 both beats, ram_a_we passes 01 then 10.
- Overlap:
  - stimulus: fill bank 1 while draining bank 0; issue rd_done and wr_done in the same cycle.
  - required: rd_bank=1 with rd_avail=1; bank 0 becomes FILLING next cycle; wr_ready returns to 1.
- Writer stall: both banks FULL -> wr_ready=0, writes suppressed, until rd_done; wr_ready=1 one cycle later.
- Errors (with BUF_PINGPONG_ERR_EN):
  - stimulus: wr_ofs=104, or rd_en with rd_avail=0.
  - required: no RAM access, err=1 and held until rst_n asserted mid-stream, which then restores the reset state.
